// File: rtl/leaf_out_packetizer_if.sv
// Bus bundle for the leaf output packetizer: user output streams, credit and
// resend controls, and the BFT-bound packet.
interface leaf_out_packetizer_if #(
   parameter int unsigned NUM_OUT_PORTS = 7,
   parameter int unsigned PAYLOAD_BITS  = 32,
   parameter int unsigned PACKET_BITS   = 49
);
   logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
   logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
   logic [NUM_OUT_PORTS-1:0]              ack_interface2user;
   logic [NUM_OUT_PORTS-1:0]              credit_rtn;
   logic                                  resend;
   logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;

   // User kernel / BFT side
   modport master (
      output din_leaf_user2interface,
      output vld_user2interface,
      output credit_rtn,
      output resend,
      input  ack_interface2user,
      input  dout_leaf_interface2bft
   );

   // Packetizer side
   modport slave (
      input  din_leaf_user2interface,
      input  vld_user2interface,
      input  credit_rtn,
      input  resend,
      output ack_interface2user,
      output dout_leaf_interface2bft
   );
endinterface

// File: rtl/leaf_out_packetizer.sv
// Leaf output packetizer: round-robin arbitration over user output streams with
// per-port credit flow control, stamping destination/address onto each payload.
module leaf_out_packetizer #(
   parameter int unsigned PACKET_BITS           = 49,
   parameter int unsigned PAYLOAD_BITS          = 32,
   parameter int unsigned NUM_LEAF_BITS         = 5,
   parameter int unsigned NUM_PORT_BITS         = 4,
   parameter int unsigned NUM_ADDR_BITS         = 7,
   parameter int unsigned NUM_OUT_PORTS         = 7,
   parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   leaf_out_packetizer_if.slave     bus,
   input  logic                     cfg_we,
   input  logic [NUM_PORT_BITS-1:0] cfg_port,
   input  logic [NUM_LEAF_BITS-1:0] cfg_leaf,
   input  logic [NUM_PORT_BITS-1:0] cfg_dport
);

   localparam int unsigned PTR_BITS    = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
   localparam int unsigned CREDIT_BITS = NUM_ADDR_BITS + 1;
   localparam int unsigned CREDIT_MAX  = 1 << NUM_ADDR_BITS;

   logic [PAYLOAD_BITS-1:0]  din_arr  [NUM_OUT_PORTS];
   logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_OUT_PORTS];
   logic [NUM_PORT_BITS-1:0] dport_q  [NUM_OUT_PORTS];
   logic [NUM_ADDR_BITS-1:0] addr_q   [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
   logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];
   logic [NUM_OUT_PORTS-1:0] en_q;

   logic [PTR_BITS-1:0]      rr_ptr_q;
   logic [PTR_BITS-1:0]      rr_ptr_d;
   logic [NUM_OUT_PORTS-1:0] elig_c;
   logic [NUM_OUT_PORTS-1:0] grant_c;
   logic                     grant_vld_c;
   logic [PTR_BITS-1:0]      grant_idx_c;
   logic                     cfg_hit_c;
   logic [PACKET_BITS-1:0]   dout_q;

   // Per-port payload view and eligibility
   for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_port
      assign din_arr[i] = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      assign elig_c[i]  = bus.vld_user2interface[i] & en_q[i] &
                          (credit_q[i] != '0) & ~bus.resend;
   end

   // Round-robin search starting at the pointer, wrapping at NUM_OUT_PORTS
   always_comb begin : p_arb
      logic [PTR_BITS-1:0] cand;
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
         if (32'(rr_ptr_q) + k >= NUM_OUT_PORTS)
            cand = PTR_BITS'(32'(rr_ptr_q) + k - NUM_OUT_PORTS);
         else
            cand = PTR_BITS'(32'(rr_ptr_q) + k);
         if (!grant_vld_c && elig_c[cand]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = cand;
         end
      end
   end

   always_comb begin : p_grant
      grant_c = '0;
      if (grant_vld_c)
         grant_c[grant_idx_c] = 1'b1;
   end

   assign bus.ack_interface2user = grant_c;

   always_comb begin : p_ptr
      rr_ptr_d = rr_ptr_q;
      if (grant_vld_c) begin
         if (32'(grant_idx_c) == NUM_OUT_PORTS - 1)
            rr_ptr_d = '0;
         else
            rr_ptr_d = grant_idx_c + PTR_BITS'(1);
      end
   end

   // Grant consumes one credit, a return adds a block; the sum saturates at buffer depth
   always_comb begin : p_credit
      int unsigned sum;
      sum = 0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
         sum = 32'(credit_q[i])
             + (bus.credit_rtn[i] ? FREESPACE_UPDATE_SIZE : 32'd0)
             - 32'(grant_c[i]);
         credit_d[i] = (sum > CREDIT_MAX) ? CREDIT_BITS'(CREDIT_MAX) : CREDIT_BITS'(sum);
      end
   end

   assign cfg_hit_c = cfg_we && (32'(cfg_port) < NUM_OUT_PORTS);

   // Destination table; a rewrite leaves credits and address counter alone
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         en_q <= '0;
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            leaf_q[i]  <= '0;
            dport_q[i] <= '0;
         end
      end else if (cfg_hit_c) begin
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            if (32'(cfg_port) == i) begin
               en_q[i]    <= 1'b1;
               leaf_q[i]  <= cfg_leaf;
               dport_q[i] <= cfg_dport;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q <= '0;
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            addr_q[i]   <= '0;
            credit_q[i] <= CREDIT_BITS'(CREDIT_MAX);
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_q[i] <= credit_d[i];
            if (grant_c[i])
               addr_q[i] <= addr_q[i] + NUM_ADDR_BITS'(1);
         end
      end
   end

   // Packet register: one cycle after the grant edge, zero otherwise
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         dout_q <= '0;
      else if (grant_vld_c)
         dout_q <= {1'b1, leaf_q[grant_idx_c], dport_q[grant_idx_c],
                    addr_q[grant_idx_c], din_arr[grant_idx_c]};
      else
         dout_q <= '0;
   end

   assign bus.dout_leaf_interface2bft = dout_q;

endmodule
